// File: rtl/if_stage.sv
// Instruction-fetch stage: issues word fetches to instruction memory and holds
// one fetched instruction in a buffer until IF/ID accepts it.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] IR_out,
    output logic        valid_out,
    output logic        ifid_write,
    output logic        ifid_flush
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;

    logic        can_issue;
    logic        completion;
    logic        take;
    logic [31:0] next_addr;
    logic [31:0] redirect_target;

    // A new fetch may start only if its result is guaranteed a buffer slot.
    assign ifid_write      = valid_out && !stall && !redirect && !rst;
    assign ifid_flush      = redirect && !rst;
    assign can_issue       = (!valid_out || ifid_write) && !redirect && !rst;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = pc;
        completion = 1'b0;
        case (state)
            IDLE: begin
                imem_req   = can_issue;
                imem_addr  = pc;
                completion = can_issue && imem_ready;
            end
            BUSY: begin
                imem_req   = !rst;
                imem_addr  = req_addr;
                completion = imem_ready;
            end
            DISCARD: begin
                imem_req   = !rst;
                imem_addr  = req_addr;
                completion = 1'b0;
            end
            default: begin
                imem_req   = 1'b0;
                imem_addr  = pc;
                completion = 1'b0;
            end
        endcase
    end

    // The address in flight is always imem_addr, so its successor is shared.
    assign take      = completion && !redirect;
    assign next_addr = imem_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC & ~32'h0000_0003;
            req_addr  <= 32'h0000_0000;
            valid_out <= 1'b0;
            PC_out    <= 32'h0000_0000;
            IR_out    <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (can_issue) begin
                        req_addr <= pc;
                        if (!imem_ready)
                            state <= BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ready)
                        state <= IDLE;
                    else if (redirect)
                        state <= DISCARD;
                end
                DISCARD: begin
                    if (imem_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Redirect outranks both a same-cycle completion and a stall.
            if (redirect) begin
                pc        <= redirect_target;
                valid_out <= 1'b0;
            end else if (take) begin
                IR_out    <= imem_rdata;
                PC_out    <= next_addr;
                pc        <= next_addr;
                valid_out <= 1'b1;
            end else if (ifid_write) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  hazard-unit freeze; IF/ID must not load.
REQ-005 redirect  in  1  taken branch/jump from downstream; one-cycle pulse.
REQ-006 redirect_pc  in  32  target address, valid when redirect=1.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  word address of request.
REQ-009 imem_ready  in  1  memory completes request this cycle.
REQ-010 imem_rdata  in  32  instruction word, valid when imem_req&&imem_ready.
REQ-011 PC_out  out  32  fetched instruction address + 4, registered; feeds IF/ID PC_in.
REQ-012 IR_out  out  32  fetched instruction, registered; feeds IF/ID IR_in.
REQ-013 valid_out  out  1  output buffer holds an unconsumed instruction.
REQ-014 ifid_write  out  1  drives IF/ID Write; = valid_out && !stall && !redirect.
REQ-015 ifid_flush  out  1  drives IF/ID rst; = redirect (combinational).

Function
REQ-016 Internal state: pc (next fetch address), req_addr, 1-entry output buffer (PC_out/IR_out/valid_out), FSM {IDLE, BUSY, DISCARD}.
REQ-017 can_issue = (!valid_out || ifid_write) && !redirect && !rst.
REQ-018 IDLE: imem_req=can_issue, imem_addr=pc; on issue req_addr<=pc; issue with imem_ready=0 -> BUSY; with imem_ready=1 -> completion, stay IDLE.
REQ-019 BUSY: imem_req=1, imem_addr=req_addr held stable; imem_ready=1 -> completion, -> IDLE; redirect with imem_ready=0 -> DISCARD.
REQ-020 DISCARD: imem_req=1, imem_addr=req_addr; imem_ready=1 -> data dropped, -> IDLE; no buffer or pc update from that data.
REQ-021 Completion (not dropped, no redirect same cycle): IR_out<=imem_rdata, PC_out<=req/issue address+4, valid_out<=1, pc<=address+4.
REQ-022 Completion in BUSY coinciding with redirect: data dropped, -> IDLE.
REQ-023 No completion and ifid_write=1: valid_out<=0.
REQ-024 Redirect (any state, priority over stall and completion): pc<={redirect_pc[31:2],2'b00}, valid_out<=0, ifid_flush=1 that cycle.
REQ-025 Stall with valid_out=1: buffer, pc and IDLE state hold; no new request issued.
REQ-026 An outstanding request always has buffer space (issue only when buffer empty or draining); completion never overwrites an unconsumed instruction.
REQ-027 Throughput: imem_ready tied 1, no stall/redirect -> one instruction per cycle, PC_out advancing by 4 each cycle.
REQ-028 Address arithmetic modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000; PC_out likewise wraps.
REQ-029 imem_addr[1:0] always 2'b00.

Reset
REQ-030 rst=1 at a clock edge: pc<=RESET_PC, state<=IDLE, valid_out<=0, PC_out<=0, IR_out<=0.
REQ-031 During rst=1 cycle imem_req=0, ifid_write=0, ifid_flush=0.
REQ-032 Reset mid-request (BUSY/DISCARD): request abandoned, no completion taken; first request after reset at RESET_PC in cycle following deassertion.

Verification
REQ-033 Reset, imem_ready=1, no stall: imem_addr 0,4,8,... each cycle; IR_out/PC_out = mem[0]/4, mem[4]/8 on successive cycles, ifid_write=1 continuous.
REQ-034 imem_ready delayed 3 cycles on addr 8: imem_req and imem_addr=8 held stable 3 cycles; valid_out stays 0 until completion; PC_out=12 after.
REQ-035 stall=1 for 4 cycles with valid_out=1 (PC_out=16): buffer holds PC_out=16, imem_req=0, ifid_write=0; stall drop -> ifid_write=1, next imem_addr=16.
REQ-036 redirect=1, redirect_pc=32'h0000_0103 while BUSY on addr 20: ifid_flush=1, valid_out->0, DISCARD until ready, returned word never on IR_out; next imem_addr=32'h0000_0100.
REQ-037 redirect and stall same cycle with valid_out=1: flush wins, ifid_write=0, valid_out->0, pc=redirect target.
REQ-038 RESET_PC=32'hFFFF_FFF8, ready=1: imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; PC_out for second fetch = 0.
